// File: rtl/fp_add_prep.sv
// Two-stage operand preparation for an IEEE-754 single-precision adder:
// stage 1 unpacks and classifies, stage 2 swaps by magnitude and aligns the smaller significand.
module fp_add_prep (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  exp_big,
  output logic [23:0] sig_big,
  output logic [26:0] sig_small,
  output logic        sign_res,
  output logic        eff_sub,
  output logic        special,
  output logic [31:0] special_result
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'h0);
  endfunction

  function automatic logic is_inf(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] == 23'h0);
  endfunction

  // Zero and denormal operands share the minimum exponent with no hidden bit.
  function automatic logic [7:0] eff_exp(input logic [31:0] f);
    return (f[30:23] == 8'h00) ? 8'h01 : f[30:23];
  endfunction

  function automatic logic [23:0] full_sig(input logic [31:0] f);
    return {(f[30:23] != 8'h00), f[22:0]};
  endfunction

  function automatic logic [26:0] align_sig(input logic [23:0] sig, input logic [7:0] d);
    logic [26:0] ext;
    logic [26:0] mask;
    ext  = {sig, 3'b000};
    mask = ~(27'h7FF_FFFF << d);
    if (d < 8'd27) begin
      return (ext >> d) | {26'h0, |(ext & mask)};
    end else begin
      return {26'h0, |sig};
    end
  endfunction

  logic        s1_valid_r;
  logic        s2_valid_r;
  logic        s1_adv_s;
  logic        s2_adv_s;

  logic        s1_sign1_r, s1_sign2_r, s1_op1_big_r, s1_special_r;
  logic [7:0]  s1_exp1_r, s1_exp2_r;
  logic [23:0] s1_sig1_r, s1_sig2_r;
  logic [31:0] s1_spec_res_r;

  logic        nan_any_s, inf1_s, inf2_s, op1_big_s, spec_s;
  logic [31:0] spec_res_s;

  logic [7:0]  eb_s, es_s, d_s;
  logic [23:0] sb_s, ss_s;
  logic        sgn_s;
  logic [7:0]  nx_exp_big_s;
  logic [23:0] nx_sig_big_s;
  logic [26:0] nx_sig_small_s;
  logic        nx_sign_res_s, nx_eff_sub_s;

  assign s2_adv_s  = !s2_valid_r || out_ready;
  assign s1_adv_s  = !s1_valid_r || s2_adv_s;
  assign in_ready  = s1_adv_s;
  assign out_valid = s2_valid_r;

  // Stage 1 classification; magnitude order compares raw {exp,mant} so ties favour op1.
  always_comb begin
    nan_any_s = is_nan(op1) || is_nan(op2);
    inf1_s    = is_inf(op1);
    inf2_s    = is_inf(op2);
    op1_big_s = (op1[30:0] >= op2[30:0]);
    spec_s    = nan_any_s || inf1_s || inf2_s;
    if (nan_any_s || (inf1_s && inf2_s && (op1[31] != op2[31]))) begin
      spec_res_s = QNAN;
    end else if (inf1_s) begin
      spec_res_s = op1;
    end else if (inf2_s) begin
      spec_res_s = op2;
    end else begin
      spec_res_s = 32'h0;
    end
  end

  // Stage 1 register: unpacked operands and special-case decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r    <= 1'b0;
      s1_sign1_r    <= 1'b0;
      s1_sign2_r    <= 1'b0;
      s1_exp1_r     <= 8'h00;
      s1_exp2_r     <= 8'h00;
      s1_sig1_r     <= 24'h0;
      s1_sig2_r     <= 24'h0;
      s1_op1_big_r  <= 1'b0;
      s1_special_r  <= 1'b0;
      s1_spec_res_r <= 32'h0;
    end else if (s1_adv_s) begin
      s1_valid_r    <= in_valid;
      s1_sign1_r    <= op1[31];
      s1_sign2_r    <= op2[31];
      s1_exp1_r     <= eff_exp(op1);
      s1_exp2_r     <= eff_exp(op2);
      s1_sig1_r     <= full_sig(op1);
      s1_sig2_r     <= full_sig(op2);
      s1_op1_big_r  <= op1_big_s;
      s1_special_r  <= spec_s;
      s1_spec_res_r <= spec_res_s;
    end else begin
      s1_valid_r    <= s1_valid_r;
    end
  end

  // Stage 2 swap and align; special pairs force the arithmetic fields to zero.
  always_comb begin
    eb_s  = 8'h00;
    es_s  = 8'h00;
    sb_s  = 24'h0;
    ss_s  = 24'h0;
    sgn_s = 1'b0;
    if (s1_op1_big_r) begin
      eb_s  = s1_exp1_r;
      es_s  = s1_exp2_r;
      sb_s  = s1_sig1_r;
      ss_s  = s1_sig2_r;
      sgn_s = s1_sign1_r;
    end else begin
      eb_s  = s1_exp2_r;
      es_s  = s1_exp1_r;
      sb_s  = s1_sig2_r;
      ss_s  = s1_sig1_r;
      sgn_s = s1_sign2_r;
    end
    d_s = eb_s - es_s;
    if (s1_special_r) begin
      nx_exp_big_s   = 8'h00;
      nx_sig_big_s   = 24'h0;
      nx_sig_small_s = 27'h0;
      nx_sign_res_s  = 1'b0;
      nx_eff_sub_s   = 1'b0;
    end else begin
      nx_exp_big_s   = eb_s;
      nx_sig_big_s   = sb_s;
      nx_sig_small_s = align_sig(ss_s, d_s);
      nx_sign_res_s  = sgn_s;
      nx_eff_sub_s   = s1_sign1_r ^ s1_sign2_r;
    end
  end

  // Stage 2 register drives the outputs directly and holds them while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r     <= 1'b0;
      exp_big        <= 8'h00;
      sig_big        <= 24'h0;
      sig_small      <= 27'h0;
      sign_res       <= 1'b0;
      eff_sub        <= 1'b0;
      special        <= 1'b0;
      special_result <= 32'h0;
    end else if (s2_adv_s) begin
      s2_valid_r     <= s1_valid_r;
      exp_big        <= nx_exp_big_s;
      sig_big        <= nx_sig_big_s;
      sig_small      <= nx_sig_small_s;
      sign_res       <= nx_sign_res_s;
      eff_sub        <= nx_eff_sub_s;
      special        <= s1_special_r;
      special_result <= s1_special_r ? s1_spec_res_r : 32'h0;
    end else begin
      s2_valid_r     <= s2_valid_r;
    end
  end

endmodule

// File: tb/tb_fp_add_prep.sv
// Bench for fp_add_prep: directed vectors, stall and reset scenarios, then random traffic
// scored against an arithmetic reference model.
module tb_fp_add_prep;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1, op2;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exp_big;
  logic [23:0] sig_big;
  logic [26:0] sig_small;
  logic        sign_res, eff_sub, special;
  logic [31:0] special_result;

  typedef struct packed {
    logic [7:0]  exp_big;
    logic [23:0] sig_big;
    logic [26:0] sig_small;
    logic        sign_res;
    logic        eff_sub;
    logic        special;
    logic [31:0] special_result;
  } out_t;

  out_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   rand_done = 1'b0;

  fp_add_prep dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
    .exp_big(exp_big), .sig_big(sig_big), .sig_small(sig_small),
    .sign_res(sign_res), .eff_sub(eff_sub), .special(special),
    .special_result(special_result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_out(input string tag, input out_t e);
    check_eq({tag, ".exp_big"},   32'(exp_big),   32'(e.exp_big));
    check_eq({tag, ".sig_big"},   32'(sig_big),   32'(e.sig_big));
    check_eq({tag, ".sig_small"}, 32'(sig_small), 32'(e.sig_small));
    check_eq({tag, ".sign_res"},  32'(sign_res),  32'(e.sign_res));
    check_eq({tag, ".eff_sub"},   32'(eff_sub),   32'(e.eff_sub));
    check_eq({tag, ".special"},   32'(special),   32'(e.special));
    check_eq({tag, ".spec_res"},  special_result, e.special_result);
  endtask

  // Reference model: IEEE rules evaluated with integer arithmetic.
  function automatic out_t ref_model(input logic [31:0] a, input logic [31:0] b);
    out_t r;
    int ea, eb, ma, mb, xa, xb, sa, sb, ebig, esml, sbig, ssml, d;
    bit a_nan, b_nan, a_inf, b_inf, a_big;
    longint v, q, rem, p;
    r  = '0;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    ma = int'(a[22:0]);  mb = int'(b[22:0]);
    a_nan = (ea == 255) && (ma != 0); a_inf = (ea == 255) && (ma == 0);
    b_nan = (eb == 255) && (mb != 0); b_inf = (eb == 255) && (mb == 0);
    if (a_nan || b_nan || a_inf || b_inf) begin
      r.special = 1'b1;
      if (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31])) r.special_result = 32'h7FC0_0000;
      else if (a_inf) r.special_result = a;
      else r.special_result = b;
      return r;
    end
    xa = (ea == 0) ? 1 : ea;  xb = (eb == 0) ? 1 : eb;
    sa = ((ea == 0) ? 0 : 8388608) + ma;
    sb = ((eb == 0) ? 0 : 8388608) + mb;
    a_big = (ea * 8388608 + ma) >= (eb * 8388608 + mb);
    ebig = a_big ? xa : xb;  esml = a_big ? xb : xa;
    sbig = a_big ? sa : sb;  ssml = a_big ? sb : sa;
    d = ebig - esml;
    if (d >= 27) begin
      r.sig_small = (ssml != 0) ? 27'd1 : 27'd0;
    end else begin
      v   = longint'(ssml) * 8;
      p   = longint'(1) << d;
      q   = v / p;
      rem = v % p;
      if (rem != 0 && (q % 2) == 0) q = q + 1;
      r.sig_small = 27'(q);
    end
    r.exp_big  = 8'(ebig);
    r.sig_big  = 24'(sbig);
    r.sign_res = a_big ? a[31] : b[31];
    r.eff_sub  = a[31] ^ b[31];
    return r;
  endfunction

  // Scoreboard: head of queue must match outputs every valid cycle, popped on transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check_eq("spurious_out", 32'(out_valid), 32'd0);
        else begin
          check_out("stream", exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(op1, op2));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bit done;
    int waited;
    done = 1'b0; waited = 0;
    op1 = a; op2 = b; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else begin
        waited++;
        if (waited > 60) begin
          check_eq("accept_timeout", 32'd1, 32'd0);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic dir(input string tag, input logic [31:0] a, input logic [31:0] b, input out_t e);
    int lat;
    send(a, b);
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check_eq({tag, ".latency"}, 32'(lat), 32'd2);
    check_out(tag, e);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_op(input logic [7:0] near, input bit use_near);
    logic [31:0] x;
    int k, e;
    x = $urandom;
    k = $urandom_range(0, 11);
    if (use_near) begin
      e = int'(near) + int'($urandom_range(0, 60)) - 30;
      if (e < 0) e = 0;
      if (e > 254) e = 254;
      x[30:23] = 8'(e);
    end
    case (k)
      0: begin x[30:23] = 8'hFF; x[22:0] = 23'h0; end
      1: x[30:23] = 8'hFF;
      2: x[30:23] = 8'h00;
      3: x[30:0] = 31'h0;
      default: ;
    endcase
    return x;
  endfunction

  initial begin
    logic [31:0] a, b;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op1 = 32'h0; op2 = 32'h0;
    #3;
    check_eq("rst.out_valid", 32'(out_valid), 32'd0);
    check_out("rst", out_t'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("rst.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    dir("d_one_one",  32'h3F80_0000, 32'h3F80_0000, out_t'{8'h7F, 24'h800000, 27'h4000000, 1'b0, 1'b0, 1'b0, 32'h0});
    dir("d_swap",     32'h3F00_0000, 32'hBF80_0000, out_t'{8'h7F, 24'h800000, 27'h2000000, 1'b1, 1'b1, 1'b0, 32'h0});
    dir("d_denorm",   32'h3F80_0000, 32'h0000_0001, out_t'{8'h7F, 24'h800000, 27'h0000001, 1'b0, 1'b0, 1'b0, 32'h0});
    dir("d_inf_inf",  32'h7F80_0000, 32'hFF80_0000, out_t'{8'h00, 24'h0, 27'h0, 1'b0, 1'b0, 1'b1, 32'h7FC00000});
    dir("d_tie",      32'h3F80_0000, 32'hBF80_0000, out_t'{8'h7F, 24'h800000, 27'h4000000, 1'b0, 1'b1, 1'b0, 32'h0});
    dir("d_inf_op2",  32'h3F80_0000, 32'hFF80_0000, out_t'{8'h00, 24'h0, 27'h0, 1'b0, 1'b0, 1'b1, 32'hFF800000});
    dir("d_nan",      32'h7F80_0001, 32'h3F80_0000, out_t'{8'h00, 24'h0, 27'h0, 1'b0, 1'b0, 1'b1, 32'h7FC00000});
    dir("d_far",      32'h4D80_0000, 32'h3F80_0000, out_t'{8'h9B, 24'h800000, 27'h0000001, 1'b0, 1'b0, 1'b0, 32'h0});
    dir("d_sticky",   32'h4080_0000, 32'h3EC0_0001, out_t'{8'h81, 24'h800000, 27'h0600001, 1'b0, 1'b0, 1'b0, 32'h0});

    // Back-to-back A..D against a four-cycle downstream stall.
    out_ready = 1'b0;
    fork
      begin
        send(32'h3F80_0000, 32'h3F00_0000);
        send(32'h4000_0000, 32'h3F80_0000);
        send(32'h4040_0000, 32'hC000_0000);
        send(32'h4080_0000, 32'h0000_0010);
      end
      begin
        repeat (2) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          check_eq("stall.out_valid", 32'(out_valid), 32'd1);
          check_eq("stall.in_ready",  32'(in_ready),  32'd0);
          check_eq("stall.hold_A",    32'(exp_big),   32'h7F);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    check_eq("stall.drained", 32'(exp_q.size()), 32'd0);

    // Reset with both stages holding pairs.
    out_ready = 1'b0;
    send(32'h7F80_0000, 32'h3F80_0000);
    send(32'h3F80_0000, 32'h4000_0000);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst.out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst.special",   32'(special), 32'd0);
    check_eq("mid_rst.spec_res",  special_result, 32'h0);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("mid_rst.in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check_eq("mid_rst.no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Random traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          a = rand_op(8'h00, 1'b0);
          b = rand_op(a[30:23], $urandom_range(0, 1) == 1);
          if ($urandom_range(0, 1) == 1) send(a, b);
          else send(b, a);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (6) @(posedge clk); #1;
    check_eq("rand.drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_add_prep.md
FP_ADD_PREP -- requirements
Module: fp_add_prep

Interface
REQ-001 Parameters SHALL be none; all widths are fixed for IEEE-754 single precision.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair on op1/op2 is valid.
REQ-005 in_ready  output  1  block accepts the pair this cycle.
REQ-006 op1, op2  input  32 each  IEEE-754 single operands.
REQ-007 out_valid  output  1  prepared pair is valid.
REQ-008 out_ready  input  1  downstream adder stage consumes this cycle.
REQ-009 exp_big  output  8  effective exponent of the larger-magnitude operand.
REQ-010 sig_big  output  24  significand of the larger operand, hidden bit included.
REQ-011 sig_small  output  27  aligned smaller significand, as {24-bit sig, guard, round, sticky}.
REQ-012 sign_res  output  1  sign of the larger operand.
REQ-013 eff_sub  output  1  op1.sign XOR op2.sign.
REQ-014 special  output  1  special_result is final and the add SHALL be bypassed.
REQ-015 special_result  output  32  final IEEE result when special=1, else 0.

Function
REQ-016 Pipeline SHALL have two register stages.
- S1: unpack and classify.
- S2: swap and align.
- Latency is exactly 2 cycles from the in_valid&in_ready edge to out_valid when unstalled.
- Throughput SHALL be 1 pair/cycle.
REQ-017 A transfer SHALL occur on valid&ready at a rising clk edge; no combinational path from out_ready to out_valid is allowed.
REQ-018 Stall logic:
- S2 advances when !s2_valid || out_ready.
- S1 advances when !s1_valid || s2 advances.
- in_ready = S1 advances.
REQ-019 While out_valid=1 && out_ready=0, all outputs SHALL hold stable; no pair is dropped, duplicated or reordered.
REQ-020 Unpack per operand:
- Normal: hidden bit = 1, effective exponent = the encoded exponent.
- Exponent 0 (zero/denormal): hidden bit = 0, effective exponent = 1.
REQ-021 Classification is NaN when exp=0xFF and mant!=0, Inf when exp=0xFF and mant=0.
REQ-022 special SHALL be 1 when either operand is NaN or Inf, with special_result as follows:
- Any NaN, or Inf plus Inf of opposite sign: 0x7FC00000.
- Otherwise: the Inf operand; when both are Inf, op1.
REQ-023 Larger operand SHALL be chosen by unsigned compare of {exp,mant}; on a tie, op1 is taken as larger.
REQ-024 d = exp_big - exp_small is unsigned and SHALL be 0..254.
REQ-025 Alignment for d<27:
- sig_small = ({sig_s,3'b000} >> d) with bit0 ORed with every shifted-out bit.
REQ-026 Alignment for d>=27: sig_small = {26'b0, |sig_s}.
REQ-027 When special=1, the other data outputs SHALL be driven to 0.
REQ-028 The block SHALL NOT round, normalise or modify exponents beyond REQ-020; that work belongs to the downstream adder.

Reset
REQ-029 While rst_n=0, the following SHALL be 0 immediately, independent of clk:
- s1_valid, s2_valid, out_valid.
- All data output registers.
REQ-030 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight pairs, with no output emitted for them after release.

Verification
REQ-032 op1=0x3F800000, op2=0x3F800000, out_ready=1 -> two cycles later:
- exp_big=0x7F, sig_big=0x800000, sig_small=0x4000000.
- eff_sub=0, sign_res=0, special=0.
REQ-033 op1=0x3F000000, op2=0xBF800000 -> swap:
- exp_big=0x7F, sig_big=0x800000, sig_small=0x2000000.
- sign_res=1, eff_sub=1.
REQ-034 op1=0x3F800000, op2=0x00000001 (d=126) -> sig_small=0x0000001, exp_big=0x7F.
REQ-035 op1=0x7F800000, op2=0xFF800000 -> special=1, special_result=0x7FC00000.
REQ-036 Back-to-back pairs A,B,C,D with out_ready=0 for 4 cycles:
- out_valid=1 holding A.
- in_ready falls after B is accepted.
- C is not accepted while stalled.
- With out_ready=1, A,B,C,D emerge in order, once each.
REQ-037 Reset mid-operation: rst_n pulsed low with both stages valid -> out_valid=0 in the same cycle; no stale pair appears after release; in_ready=1.
